cache_flush_walker: RTL

Sequencer that walks every set and every way of a set-associative data cache during a cache flush (CMO/fence-style flush request).
- Per line, it drives the flush address and a one-hot flush way into the ways' flush select path.
- It checks the returned dirty indication. For a dirty line it issues a writeback request to the bus/writeback logic, waits for completion, then clears the dirty bit.
- It sits between the cache FSM (start, stall, done) and the way array (FlushCache, FlushWay, flush address, ClearDirty).

---
 rtl/cache_flush_walker.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cache_flush_walker.sv
// cache_flush_walker: walks every set and way of a set-associative data cache on a flush.
// For each line it presents the set index and a one-hot way to the way array, samples the
// returned dirty flag, and for a dirty line requests a writeback, waits for completion and
// then pulses ClearDirty.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   FlushReq        start a full-cache flush (IDLE only)
//   Stall           freeze state; pulse outputs suppressed while high
//   LineDirty       dirty flag of the selected line, valid in the cycle after READ
//   WriteBackDone   writeback of the current line completed
//   FlushCache      way-array flush select active
//   FlushAdr        set index being flushed
//   FlushWay        one-hot way being flushed (zero in IDLE)
//   WriteBackReq    writeback request for (FlushAdr, FlushWay)
//   ClearDirty      one-cycle dirty-bit clear for the selected way
//   FlushBusy       walker not in IDLE
//   FlushDone       one-cycle completion pulse
//   ClearValid      (CACHE_FLUSH_INVALIDATE_EN only) one-cycle valid-bit clear per line
//
// Optional feature macro: CACHE_FLUSH_INVALIDATE_EN turns the flush into flush-and-invalidate.
module cache_flush_walker #(
    parameter int unsigned NUMSETS = 512,
    parameter int unsigned NUMWAYS = 4,
    localparam int unsigned SETLEN = $clog2(NUMSETS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushReq,
    input  logic               Stall,
    input  logic               LineDirty,
    input  logic               WriteBackDone,
    output logic               FlushCache,
    output logic [SETLEN-1:0]  FlushAdr,
    output logic [NUMWAYS-1:0] FlushWay,
    output logic               WriteBackReq,
    output logic               ClearDirty,
    output logic               FlushBusy,
    output logic               FlushDone
`ifdef CACHE_FLUSH_INVALIDATE_EN
    ,
    output logic               ClearValid
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCheck,
        StWb,
        StClr,
        StDone
    } state_t;

    state_t              r_state;
    logic [SETLEN-1:0]   r_adr;
    logic [NUMWAYS-1:0]  r_way;
    logic                r_busy;
    logic                r_wb_req;

    logic                w_last_way;
    logic                w_last_set;
    logic                w_walk_end;
    logic [SETLEN-1:0]   w_next_adr;
    logic [NUMWAYS-1:0]  w_next_way;

    // Next line position: rotate the one-hot way; on the last way wrap to way 0 of the next set.
    // With a single way the last-way flag is always set, so every advance bumps the set.
    always_comb begin
        w_last_way = r_way[NUMWAYS-1];
        w_last_set = (r_adr == SETLEN'(NUMSETS - 1));
        w_walk_end = w_last_way & w_last_set;
        w_next_way = w_last_way ? NUMWAYS'(1) : (r_way << 1);
        w_next_adr = w_last_way ? (r_adr + SETLEN'(1)) : r_adr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_adr    <= '0;
            r_way    <= '0;
            r_busy   <= 1'b0;
            r_wb_req <= 1'b0;
        end else if (!Stall) begin
            unique case (r_state)
                StIdle: begin
                    if (FlushReq) begin
                        r_state <= StRead;
                        r_adr   <= '0;
                        r_way   <= NUMWAYS'(1);
                        r_busy  <= 1'b1;
                    end
                end
                StRead: r_state <= StCheck;
                StCheck: begin
                    if (LineDirty) begin
                        r_state  <= StWb;
                        r_wb_req <= 1'b1;
                    end else if (w_walk_end) begin
                        r_state <= StDone;
                    end else begin
                        r_state <= StRead;
                        r_adr   <= w_next_adr;
                        r_way   <= w_next_way;
                    end
                end
                StWb: begin
                    if (WriteBackDone) begin
                        r_state  <= StClr;
                        r_wb_req <= 1'b0;
                    end
                end
                StClr: begin
                    if (w_walk_end) begin
                        r_state <= StDone;
                    end else begin
                        r_state <= StRead;
                        r_adr   <= w_next_adr;
                        r_way   <= w_next_way;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_adr   <= '0;
                    r_way   <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= StIdle;
                    r_busy   <= 1'b0;
                    r_wb_req <= 1'b0;
                end
            endcase
        end
    end

    assign FlushCache   = r_busy;
    assign FlushBusy    = r_busy;
    assign FlushAdr     = r_adr;
    assign FlushWay     = r_way;
    assign WriteBackReq = r_wb_req;
    // Pulses are gated by Stall so a stalled cycle re-issues them once Stall drops.
    assign ClearDirty   = (r_state == StClr) & ~Stall;
    assign FlushDone    = (r_state == StDone) & ~Stall;
`ifdef CACHE_FLUSH_INVALIDATE_EN
    // One pulse per line, coincident with its advance.
    assign ClearValid   = ~Stall & ((r_state == StClr) | ((r_state == StCheck) & ~LineDirty));
`endif

endmodule
